// File: rtl/imm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imm_pkg
// Description : Immediate-format enumeration and RV base opcode constants
//               shared by the immediate decode stage and its extractor.
// Revision    : 1.0 - initial release
// ============================================================================
package imm_pkg;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5,
        IMM_Z    = 3'd6
    } imm_type_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

endpackage
`default_nettype wire

// File: rtl/imm_decode_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : imm_decode_stage_if
// Description : Upstream/downstream valid-ready bundle of the decode stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface imm_decode_stage_if #(
    parameter int XLEN = 32,
    parameter int PCW  = XLEN
);
    import imm_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [PCW-1:0]  in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_inst;
    logic [PCW-1:0]  out_pc;
    logic [XLEN-1:0] out_imm;
    imm_type_e       out_imm_type;
    logic [PCW-1:0]  out_target;
    logic            out_illegal;

    // Stage side
    modport slave (
        input  in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_inst, out_pc, out_imm,
               out_imm_type, out_target, out_illegal
    );

    // Environment side
    modport master (
        output in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_inst, out_pc, out_imm,
               out_imm_type, out_target, out_illegal
    );
endinterface
`default_nettype wire

// File: rtl/imm_extract.sv
`default_nettype none
// ============================================================================
// Module      : imm_extract
// Description : Combinational RV immediate extraction: format, value, illegal.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_extract
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst_i,
    output logic [XLEN-1:0] imm_o,
    output imm_type_e       imm_type_o,
    output logic            illegal_o
);

    logic [31:0] w_imm32;
    logic        w_unused;

    // funct3 bits other than inst[14] never influence the immediate
    assign w_unused = ^inst_i[13:12];

    always_comb begin
        imm_type_o = IMM_NONE;
        illegal_o  = 1'b0;
        case (inst_i[6:0])
            OP_LOAD, OP_IMM, OP_JALR, OP_FENCE: imm_type_o = IMM_I;
            OP_STORE:                           imm_type_o = IMM_S;
            OP_BRANCH:                          imm_type_o = IMM_B;
            OP_AUIPC, OP_LUI:                   imm_type_o = IMM_U;
            OP_JAL:                             imm_type_o = IMM_J;
            OP_OP:                              imm_type_o = IMM_NONE;
            OP_SYSTEM: imm_type_o = inst_i[14] ? IMM_Z : IMM_I;
            default:                            illegal_o  = 1'b1;
        endcase
    end

    // Every format fits in 32 bits; Z keeps bit 31 clear so the widening
    // sign extension below leaves it zero-extended.
    always_comb begin
        w_imm32 = '0;
        case (imm_type_o)
            IMM_I: w_imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
            IMM_S: w_imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            IMM_B: w_imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7],
                              inst_i[30:25], inst_i[11:8], 1'b0};
            IMM_U: w_imm32 = {inst_i[31:12], 12'b0};
            IMM_J: w_imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12],
                              inst_i[20], inst_i[30:21], 1'b0};
            IMM_Z: w_imm32 = {27'b0, inst_i[19:15]};
            default: w_imm32 = '0;
        endcase
    end

    assign imm_o = XLEN'($signed(w_imm32));

endmodule
`default_nettype wire

// File: rtl/imm_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : imm_decode_stage
// Description : Two-entry (main + skid) pipeline stage decoding RV immediates
//               and branch/jump targets with a registered in_ready.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_decode_stage
    import imm_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int PCW  = XLEN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    imm_decode_stage_if.slave bus
);

    typedef struct packed {
        logic [31:0]     inst;
        logic [PCW-1:0]  pc;
        logic [XLEN-1:0] imm;
        imm_type_e       imm_type;
        logic [PCW-1:0]  target;
        logic            illegal;
    } entry_t;

    logic [XLEN-1:0] w_imm;
    imm_type_e       w_imm_type;
    logic            w_illegal;
    entry_t          w_entry;
    logic            w_accept;
    logic            w_consume;

    entry_t main_q, main_d, skid_q, skid_d;
    logic   main_valid_q, main_valid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   in_ready_q;

    imm_extract #(.XLEN(XLEN)) u_extract (
        .inst_i     (bus.in_inst),
        .imm_o      (w_imm),
        .imm_type_o (w_imm_type),
        .illegal_o  (w_illegal)
    );

    // Decode and target add happen before storage, so both registers hold
    // finished results and the outputs are pure flop outputs.
    always_comb begin
        w_entry.inst     = bus.in_inst;
        w_entry.pc       = bus.in_pc;
        w_entry.imm      = w_imm;
        w_entry.imm_type = w_imm_type;
        w_entry.target   = bus.in_pc + PCW'($signed(w_imm));
        w_entry.illegal  = w_illegal;
    end

    assign w_accept  = bus.in_valid & in_ready_q;
    assign w_consume = main_valid_q & bus.out_ready;

    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (w_consume) begin
            // in_ready is low whenever skid is occupied, so no accept here
            if (skid_valid_q) begin
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else if (w_accept) begin
                main_d       = w_entry;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (w_accept) begin
            if (main_valid_q) begin
                skid_d       = w_entry;
                skid_valid_d = 1'b1;
            end else begin
                main_d       = w_entry;
                main_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= ~skid_valid_d;
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.out_valid    = main_valid_q;
    assign bus.out_inst     = main_q.inst;
    assign bus.out_pc       = main_q.pc;
    assign bus.out_imm      = main_q.imm;
    assign bus.out_imm_type = main_q.imm_type;
    assign bus.out_target   = main_q.target;
    assign bus.out_illegal  = main_q.illegal;

endmodule
`default_nettype wire

// File: tb/tb_imm_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_decode_stage
// Description : Self-checking bench for imm_decode_stage at XLEN 32 and 64.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_decode_stage;
    import imm_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    always #5 clk = ~clk;

    imm_decode_stage_if #(.XLEN(32)) b32 ();
    imm_decode_stage_if #(.XLEN(64)) b64 ();

    imm_decode_stage #(.XLEN(32)) dut32 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(b32.slave));
    imm_decode_stage #(.XLEN(64)) dut64 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(b64.slave));

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [63:0] pc64;
    } txn_t;

    txn_t        q[$];
    logic [31:0] seen[$];
    bit          rdy_known = 1'b0;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference decode straight from the format rules, via signed arithmetic
    function automatic void ref_decode(input logic [31:0] inst, input int xlen,
                                       output logic [63:0] imm, output imm_type_e t,
                                       output bit ill);
        longint s;
        s   = longint'($signed(inst));
        ill = 1'b0;
        t   = IMM_NONE;
        imm = '0;
        case (inst[6:0])
            OP_LOAD, OP_IMM, OP_JALR, OP_FENCE: t = IMM_I;
            OP_STORE:         t = IMM_S;
            OP_BRANCH:        t = IMM_B;
            OP_AUIPC, OP_LUI: t = IMM_U;
            OP_JAL:           t = IMM_J;
            OP_OP:            t = IMM_NONE;
            OP_SYSTEM:        t = inst[14] ? IMM_Z : IMM_I;
            default:          ill = 1'b1;
        endcase
        case (t)
            IMM_I: imm = s >>> 20;
            IMM_S: imm = ((s >>> 25) << 5) | longint'(inst[11:7]);
            IMM_B: imm = ((s >>> 31) << 12) | (longint'(inst[7]) << 11)
                       | (longint'(inst[30:25]) << 5) | (longint'(inst[11:8]) << 1);
            IMM_U: imm = s & 64'hFFFF_FFFF_FFFF_F000;
            IMM_J: imm = ((s >>> 31) << 20) | (longint'(inst[19:12]) << 12)
                       | (longint'(inst[20]) << 11) | (longint'(inst[30:21]) << 1);
            IMM_Z: imm = longint'(inst[19:15]);
            default: imm = '0;
        endcase
        if (xlen == 32) imm = {32'b0, imm[31:0]};
    endfunction

    task automatic compare_all();
        logic [63:0] imm32, imm64, tgt32;
        imm_type_e   t32, t64;
        bit          ill32, ill64;
        bit          ev;
        ev = (q.size() > 0);
        check_eq("out_valid32", b32.out_valid, ev);
        check_eq("out_valid64", b64.out_valid, ev);
        if (rdy_known) begin
            check_eq("in_ready32", b32.in_ready, q.size() < 2);
            check_eq("in_ready64", b64.in_ready, q.size() < 2);
        end
        if (ev) begin
            ref_decode(q[0].inst, 32, imm32, t32, ill32);
            ref_decode(q[0].inst, 64, imm64, t64, ill64);
            tgt32 = {32'b0, q[0].pc + imm32[31:0]};
            check_eq("inst32",    b32.out_inst,     q[0].inst);
            check_eq("pc32",      b32.out_pc,       q[0].pc);
            check_eq("imm32",     b32.out_imm,      imm32);
            check_eq("type32",    b32.out_imm_type, t32);
            check_eq("target32",  b32.out_target,   tgt32);
            check_eq("illegal32", b32.out_illegal,  ill32);
            check_eq("inst64",    b64.out_inst,     q[0].inst);
            check_eq("pc64",      b64.out_pc,       q[0].pc64);
            check_eq("imm64",     b64.out_imm,      imm64);
            check_eq("type64",    b64.out_imm_type, t64);
            check_eq("target64",  b64.out_target,   q[0].pc64 + imm64);
            check_eq("illegal64", b64.out_illegal,  ill64);
        end
    endtask

    task automatic step(input bit v, input logic [31:0] inst, input logic [31:0] pc,
                        input bit ordy, input bit fl, output bit accepted);
        logic [63:0] pc64;
        bit          exp_rdy;
        pc64          = {$urandom(), pc};
        b32.in_valid  = v;    b64.in_valid  = v;
        b32.in_inst   = inst; b64.in_inst   = inst;
        b32.in_pc     = pc;   b64.in_pc     = pc64;
        b32.out_ready = ordy; b64.out_ready = ordy;
        flush         = fl;
        exp_rdy       = rdy_known && (q.size() < 2);
        accepted      = 1'b0;
        @(posedge clk);
        if (b32.out_valid && ordy && !fl) seen.push_back(b32.out_inst);
        if (fl) begin
            q.delete();
        end else begin
            if (ordy && q.size() > 0) void'(q.pop_front());
            if (v && exp_rdy) begin
                q.push_back('{inst: inst, pc: pc, pc64: pc64});
                accepted = 1'b1;
            end
        end
        if (rst_n) rdy_known = 1'b1;
        #1;
        compare_all();
    endtask

    function automatic logic [31:0] rand_inst();
        logic [6:0]  ops [11];
        logic [31:0] r;
        int          k;
        ops = '{OP_LOAD, OP_IMM, OP_JALR, OP_FENCE, OP_STORE, OP_BRANCH,
                OP_AUIPC, OP_LUI, OP_JAL, OP_OP, OP_SYSTEM};
        r = $urandom();
        k = $urandom_range(0, 12);
        if (k < 11) return {r[31:7], ops[k]};
        return r;
    endfunction

    initial begin
        bit          acc;
        logic [31:0] sent[$];
        int          cyc;

        b32.in_valid = 1'b0; b32.in_inst = '0; b32.in_pc = '0; b32.out_ready = 1'b0;
        b64.in_valid = 1'b0; b64.in_inst = '0; b64.in_pc = '0; b64.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_out_valid", b32.out_valid, 0);
        check_eq("rst_out_imm",   b32.out_imm, 0);
        check_eq("rst_target",    b32.out_target, 0);
        check_eq("rst_out_inst",  b64.out_inst, 0);
        check_eq("rst_out_valid64", b64.out_valid, 0);
        rst_n = 1'b1;
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
        check_eq("ready_after_rst", b32.in_ready, 1);

        // Directed decode vectors
        step(1'b1, 32'hFFF0_0093, 32'h100, 1'b1, 1'b0, acc);
        check_eq("addi_imm",    b32.out_imm, 32'hFFFF_FFFF);
        check_eq("addi_type",   b32.out_imm_type, IMM_I);
        check_eq("addi_target", b32.out_target, 32'h0000_00FF);
        check_eq("addi_ill",    b32.out_illegal, 0);
        check_eq("addi_imm64",  b64.out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        step(1'b1, 32'hFE00_0EE3, 32'h200, 1'b1, 1'b0, acc);
        check_eq("beq_imm",     b32.out_imm, 32'hFFFF_FFFC);
        check_eq("beq_type",    b32.out_imm_type, IMM_B);
        check_eq("beq_target",  b32.out_target, 32'h1FC);
        step(1'b1, 32'h1234_50B7, 32'h300, 1'b1, 1'b0, acc);
        check_eq("lui_imm",     b32.out_imm, 32'h1234_5000);
        check_eq("lui_type",    b32.out_imm_type, IMM_U);
        step(1'b1, 32'h3401_D073, 32'h400, 1'b1, 1'b0, acc);
        check_eq("csrrwi_type64", b64.out_imm_type, IMM_Z);
        check_eq("csrrwi_imm64",  b64.out_imm, 64'h3);
        step(1'b1, 32'h0000_007F, 32'h500, 1'b1, 1'b0, acc);
        check_eq("illeg_flag",  b32.out_illegal, 1);
        check_eq("illeg_imm",   b32.out_imm, 0);
        check_eq("illeg_type",  b32.out_imm_type, IMM_NONE);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);

        // Five-entry stream with the consumer stalled for three cycles
        seen.delete();
        for (int i = 0; i < 5; i++) sent.push_back(rand_inst());
        cyc = 0;
        for (int n = 0; n < 5 && cyc < 30; cyc++) begin
            step(1'b1, sent[n], 32'h1000 + 32'(n * 4), !(cyc >= 2 && cyc <= 4), 1'b0, acc);
            if (acc) n++;
            if (cyc == 3) check_eq("stall_in_ready", b32.in_ready, 0);
        end
        for (int i = 0; i < 10 && q.size() > 0; i++)
            step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
        check_eq("stream_count", seen.size(), 5);
        for (int i = 0; i < 5 && i < seen.size(); i++)
            check_eq("stream_order", seen[i], sent[i]);

        // Fill both registers, then flush with an entry on offer
        step(1'b1, rand_inst(), 32'h2000, 1'b0, 1'b0, acc);
        step(1'b1, rand_inst(), 32'h2004, 1'b0, 1'b0, acc);
        check_eq("full_in_ready", b32.in_ready, 0);
        step(1'b1, 32'h0AB0_0093, 32'h2008, 1'b0, 1'b1, acc);
        check_eq("flush_out_valid", b32.out_valid, 0);
        check_eq("flush_in_ready",  b32.in_ready, 1);
        repeat (3) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);

        // Randomized traffic with occasional flushes
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, rand_inst(), $urandom(),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0, acc);

        // Asynchronous reset in the middle of traffic
        step(1'b1, rand_inst(), 32'h3000, 1'b0, 1'b0, acc);
        step(1'b1, rand_inst(), 32'h3004, 1'b0, 1'b0, acc);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_valid32", b32.out_valid, 0);
        check_eq("async_rst_valid64", b64.out_valid, 0);
        check_eq("async_rst_imm",     b32.out_imm, 0);
        q.delete();
        rdy_known = 1'b0;
        b32.in_valid = 1'b0; b64.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 60; i++)
            step($urandom_range(0, 1) != 0, rand_inst(), $urandom(),
                 $urandom_range(0, 2) != 0, 1'b0, acc);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/imm_decode_stage.md
IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 Parameter PCW, default XLEN, program-counter width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 flush  input  1  synchronous kill of all buffered entries.
REQ-006 in_valid  input  1  upstream entry present.
REQ-007 in_ready  output  1  stage can accept an entry this cycle.
REQ-008 in_inst  input  32  raw RV instruction word.
REQ-009 in_pc  input  PCW  address of in_inst.
REQ-010 out_valid  output  1  decoded entry present.
REQ-011 out_ready  input  1  downstream consumes entry this cycle.
REQ-012 out_inst  output  32  instruction passthrough.
REQ-013 out_pc  output  PCW  pc passthrough.
REQ-014 out_imm  output  XLEN  sign/zero-extended immediate.
REQ-015 out_imm_type  output  3  imm_type_e: NONE, I, S, B, U, J, Z.
REQ-016 out_target  output  PCW  pc + imm, modulo 2^PCW.
REQ-017 out_illegal  output  1  opcode not in supported set.

Function
REQ-018 Opcode mapping: 0000011, 0010011, 1100111, 0001111 -> I; 0100011 -> S; 1100011 -> B; 0010111, 0110111 -> U; 1101111 -> J; 0110011 -> NONE (imm 0); 1110011 with inst[14]=1 -> Z, else I.
REQ-019 I/S/B/J immediates sign-extended from inst[31] to XLEN; U = inst[31:12]<<12, sign-extended to XLEN; Z = zero-extended inst[19:15].
REQ-020 Unlisted opcode: out_imm=0, out_imm_type=NONE, out_illegal=1; entry still flows, never dropped.
REQ-021 out_target computed for every entry as out_pc + out_imm truncated to PCW bits; wrap-around silent.
REQ-022 Storage: main register (drives outputs) plus one skid register; capacity 2 entries.
REQ-023 in_ready = NOT skid_valid, driven from a register (no combinational path from out_ready).
REQ-024 Accept when in_valid AND in_ready; consume when out_valid AND out_ready.
REQ-025 Latency: entry accepted in cycle N into empty stage appears on outputs in cycle N+1.
REQ-026 Throughput: one entry per cycle sustained while out_ready=1.
REQ-027 Ordering strictly FIFO; skid entry moves to main on consume in the same edge.
REQ-028 Accept while main full and not consumed -> entry goes to skid; in_ready falls next cycle.
REQ-029 Simultaneous accept and consume with skid empty -> new entry replaces main, out_valid stays 1.
REQ-030 Output fields held stable while out_valid=1 and out_ready=0.
REQ-031 flush=1: both valid bits cleared next edge; any entry offered that cycle discarded; flush wins over accept/consume.

Reset
REQ-032 rst_n low asynchronously clears main/skid valid bits and all output data to 0; out_valid=0.
REQ-033 in_ready=1 from first edge after rst_n release; reset mid-stream discards all entries.

Structure
REQ-034 Package imm_pkg holds imm_type_e enum and opcode constants (OP_LOAD, OP_IMM, OP_JALR, OP_FENCE, OP_STORE, OP_BRANCH, OP_AUIPC, OP_LUI, OP_JAL, OP_OP, OP_SYSTEM).
REQ-035 Combinational sub-module imm_extract (param XLEN): inst -> imm, imm_type, illegal; instantiated once at stage input.
REQ-036 Registers store decoded results; adder for out_target placed before main register.

Verification
REQ-037 addi 0xFFF00093, pc 0x100, XLEN=32 -> next cycle imm 0xFFFFFFFF, type I, target 0x000000FF, illegal 0.
REQ-038 beq 0xFE000EE3, pc 0x200 -> imm 0xFFFFFFFC, type B, target 0x1FC; lui 0x123450B7 -> imm 0x12345000, type U.
REQ-039 XLEN=64: addi 0xFFF00093 -> imm 0xFFFFFFFFFFFFFFFF; csrrwi 0x3401D073 -> type Z, imm 0x3.
REQ-040 Stream 5 entries, out_ready=0 cycles 2-4 -> in_ready low after 2 held, all 5 delivered in order, none duplicated.
REQ-041 Both entries full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, offered entry never appears.
REQ-042 Inst 0x0000007F -> out_illegal=1, imm 0, type NONE; rst_n pulsed low mid-stream -> out_valid=0 immediately.
